fetch_unit: RTL and testbench

Parametrised instruction-fetch block for the RISC core: merges the program counter and instruction register into one unit with a configurable-latency memory read handshake and branch support. It sits between the controller and the RAM read port, replacing the fixed single-cycle counter/IR pair. Address width, data width, reset vector and memory latency are all parameters.

---
 rtl/risc_pkg.sv | 16 +
 rtl/pc_target.sv | 40 ++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the RISC core fetch path: branch modes and fetch FSM states.
package risc_pkg;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_ABS  = 2'b01,
        BR_REL  = 2'b10,
        BR_RSV  = 2'b11
    } br_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_target.sv
// Combinational branch-target calculator; also used by the controller for link addresses.
module pc_target
    import risc_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic [1:0]    mode,
    input  logic [AW-1:0] instr_pc,
    input  logic [AW-1:0] br_target,
    input  logic [7:0]    br_off,
    output logic [AW-1:0] target,
    output logic          taken
);

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] off_ext_s;

    // Relative targets wrap modulo 2^AW; reserved and none modes never redirect.
    always_comb begin
        off_ext_s = AW'($signed(br_off));
        target    = instr_pc;
        taken     = 1'b0;
        case (mode)
            BR_ABS: begin
                target = br_target;
                taken  = 1'b1;
            end
            BR_REL: begin
                target = instr_pc + PC_ONE + off_ext_s;
                taken  = 1'b1;
            end
            default: begin
                target = instr_pc;
                taken  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: program counter, instruction register and a fixed-latency RAM read handshake.
module fetch_unit
    import risc_pkg::*;
#(
    parameter int            AW       = 8,
    parameter int            DW       = 16,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
    parameter int            MEM_LAT  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    input  logic          flush,
    input  logic          br_en,
    input  logic [1:0]    br_mode,
    input  logic [AW-1:0] br_target,
    input  logic [7:0]    br_off,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy
);

    localparam int            CNT_W  = 2;
    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    fetch_state_e  state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [AW-1:0] fetch_addr_r, fetch_addr_s;
    logic [AW-1:0] pend_r, pend_s;
    logic          pend_valid_r, pend_valid_s;
    logic [AW-1:0] pc_r, pc_s;
    logic [DW-1:0] instr_r, instr_s;
    logic [AW-1:0] instr_pc_r, instr_pc_s;
    logic          instr_valid_r, instr_valid_s;
    logic          busy_r, busy_s;
    logic          mem_req_s;
    logic [AW-1:0] mem_addr_s;
    logic [AW-1:0] tgt_s;
    logic          taken_s;
    logic          br_take_s;

    pc_target #(.AW(AW)) u_pc_target (
        .mode      (br_mode),
        .instr_pc  (instr_pc_r),
        .br_target (br_target),
        .br_off    (br_off),
        .target    (tgt_s),
        .taken     (taken_s)
    );

    assign br_take_s = br_en & taken_s;

    // Next-state, datapath updates and the combinational RAM strobe/address.
    always_comb begin
        state_s       = state_r;
        cnt_s         = cnt_r;
        fetch_addr_s  = fetch_addr_r;
        pend_s        = pend_r;
        pend_valid_s  = pend_valid_r;
        pc_s          = pc_r;
        instr_s       = instr_r;
        instr_pc_s    = instr_pc_r;
        instr_valid_s = 1'b0;
        busy_s        = busy_r;
        mem_req_s     = 1'b0;
        mem_addr_s    = pc_r;
        case (state_r)
            IDLE: begin
                if (fetch_en) begin
                    mem_req_s    = 1'b1;
                    mem_addr_s   = br_take_s ? tgt_s : pc_r;
                    fetch_addr_s = mem_addr_s;
                    cnt_s        = CNT_W'(MEM_LAT - 1);
                    pend_valid_s = 1'b0;
                    busy_s       = 1'b1;
                    state_s      = WAIT;
                end else if (br_take_s) begin
                    pc_s = tgt_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            WAIT: begin
                // Flush wins over completion; a branch seen during the fetch still lands on pc.
                if (flush) begin
                    state_s      = IDLE;
                    busy_s       = 1'b0;
                    pend_valid_s = 1'b0;
                    if (br_take_s) begin
                        pc_s = tgt_s;
                    end else if (pend_valid_r) begin
                        pc_s = pend_r;
                    end else begin
                        pc_s = pc_r;
                    end
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s       = IDLE;
                    busy_s        = 1'b0;
                    pend_valid_s  = 1'b0;
                    instr_s       = mem_rdata;
                    instr_pc_s    = fetch_addr_r;
                    instr_valid_s = 1'b1;
                    if (br_take_s) begin
                        pc_s = tgt_s;
                    end else if (pend_valid_r) begin
                        pc_s = pend_r;
                    end else begin
                        pc_s = fetch_addr_r + PC_ONE;
                    end
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (br_take_s) begin
                        pend_s       = tgt_s;
                        pend_valid_s = 1'b1;
                    end else begin
                        pend_s = pend_r;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            fetch_addr_r  <= {AW{1'b0}};
            pend_r        <= {AW{1'b0}};
            pend_valid_r  <= 1'b0;
            pc_r          <= RESET_PC;
            instr_r       <= {DW{1'b0}};
            instr_pc_r    <= {AW{1'b0}};
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            fetch_addr_r  <= fetch_addr_s;
            pend_r        <= pend_s;
            pend_valid_r  <= pend_valid_s;
            pc_r          <= pc_s;
            instr_r       <= instr_s;
            instr_pc_r    <= instr_pc_s;
            instr_valid_r <= instr_valid_s;
            busy_r        <= busy_s;
        end
    end

    assign mem_req     = mem_req_s;
    assign mem_addr    = mem_addr_s;
    assign instr       = instr_r;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = instr_valid_r;
    assign pc          = pc_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: one instance at MEM_LAT=1, one at MEM_LAT=3, selected by sel.
module tb_fetch_unit;

    typedef struct {
        logic [15:0] instr;
        logic [7:0]  ipc;
        logic [7:0]  pc;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sel = 1'b0;
    logic fetch_en = 1'b0, flush = 1'b0, br_en = 1'b0;
    logic [1:0] br_mode = 2'b00;
    logic [7:0] br_target = 8'h00, br_off = 8'h00;
    int cyc = 0;
    int lat = 1;
    int n_vec = 0, n_err = 0;
    exp_t q1[$], q3[$];
    exp_t e1, e3;

    logic mr1, mr3, v1, v3, b1, b3;
    logic [7:0] ma1, ma3, ip1, ip3, p1, p3, a1 = 8'h00, a3 = 8'h00;
    logic [15:0] rd1, rd3, i1, i3;

    logic o_mem_req, o_valid, o_busy;
    logic [7:0] o_mem_addr, o_ipc, o_pc;
    logic [15:0] o_instr;

    function automatic logic [15:0] ram_f(input logic [7:0] a);
        return 16'h1234 + {a, a};
    endfunction

    fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'h00), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en & ~sel), .flush(flush & ~sel),
        .br_en(br_en & ~sel), .br_mode(br_mode), .br_target(br_target), .br_off(br_off),
        .mem_req(mr1), .mem_addr(ma1), .mem_rdata(rd1), .instr(i1), .instr_pc(ip1),
        .instr_valid(v1), .pc(p1), .busy(b1));

    fetch_unit #(.AW(8), .DW(16), .RESET_PC(8'h00), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en & sel), .flush(flush & sel),
        .br_en(br_en & sel), .br_mode(br_mode), .br_target(br_target), .br_off(br_off),
        .mem_req(mr3), .mem_addr(ma3), .mem_rdata(rd3), .instr(i3), .instr_pc(ip3),
        .instr_valid(v3), .pc(p3), .busy(b3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: address captured on the strobe, data held until the next request.
    always @(posedge clk) if (mr1) a1 <= ma1;
    always @(posedge clk) if (mr3) a3 <= ma3;
    assign rd1 = ram_f(a1);
    assign rd3 = ram_f(a3);

    assign o_mem_req  = sel ? mr3 : mr1;
    assign o_mem_addr = sel ? ma3 : ma1;
    assign o_valid    = sel ? v3 : v1;
    assign o_busy     = sel ? b3 : b1;
    assign o_ipc      = sel ? ip3 : ip1;
    assign o_pc       = sel ? p3 : p1;
    assign o_instr    = sel ? i3 : i1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitors: pop one expectation per instr_valid pulse.
    always @(negedge clk) begin
        if (v1) begin
            if (q1.size() == 0) begin
                chk("lat1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("lat1_instr", i1, e1.instr);
                chk("lat1_instr_pc", ip1, e1.ipc);
                chk("lat1_pc", p1, e1.pc);
                chk("lat1_valid_cycle", cyc, e1.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (v3) begin
            if (q3.size() == 0) begin
                chk("lat3_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e3 = q3.pop_front();
                chk("lat3_instr", i3, e3.instr);
                chk("lat3_instr_pc", ip3, e3.ipc);
                chk("lat3_pc", p3, e3.pc);
                chk("lat3_valid_cycle", cyc, e3.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] addr, input logic [7:0] npc, input int at);
        exp_t e;
        e.instr = ram_f(addr);
        e.ipc   = addr;
        e.pc    = npc;
        e.cyc   = at;
        if (sel) q3.push_back(e);
        else     q1.push_back(e);
    endtask

    task automatic issue(input bit push, input logic brn, input logic [1:0] mode,
                         input logic [7:0] tgt, input logic [7:0] exp_addr, input logic [7:0] exp_pc);
        fetch_en  = 1'b1;
        br_en     = brn;
        br_mode   = mode;
        br_target = tgt;
        br_off    = 8'h00;
        #1;
        chk("mem_req", o_mem_req, 32'd1);
        chk("mem_addr", o_mem_addr, exp_addr);
        if (push) push_exp(exp_addr, exp_pc, cyc + lat + 1);
        tick();
        fetch_en = 1'b0;
        br_en    = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 20) begin
            tick();
            n++;
        end
        chk("busy_drop_timeout", o_busy, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, req_cnt, cyc0;
        // Reset values.
        tick();
        chk("rst_pc", o_pc, 32'h00);
        chk("rst_instr", o_instr, 32'h0);
        chk("rst_instr_pc", o_ipc, 32'h00);
        chk("rst_valid", o_valid, 32'd0);
        chk("rst_mem_req", o_mem_req, 32'd0);
        chk("rst_busy", o_busy, 32'd0);
        reset = 1'b1;
        tick();

        // MEM_LAT=1 single fetch from address 0.
        sel = 1'b0; lat = 1;
        issue(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h01);
        chk("lat1_busy", o_busy, 32'd1);
        wait_idle();
        tick();
        chk("lat1_valid_pulse_end", o_valid, 32'd0);

        // MEM_LAT=3 with fetch_en held high for 12 cycles.
        sel = 1'b1; lat = 3;
        tick();
        cyc0 = cyc;
        push_exp(8'h00, 8'h01, cyc0 + 4);
        push_exp(8'h01, 8'h02, cyc0 + 8);
        push_exp(8'h02, 8'h03, cyc0 + 12);
        busy_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            fetch_en = 1'b1;
            #1;
            if (o_busy) busy_cnt++;
            if (o_mem_req) req_cnt++;
            tick();
        end
        fetch_en = 1'b0;
        chk("held_busy_cycles", busy_cnt, 32'd9);
        chk("held_req_count", req_cnt, 32'd3);
        tick();

        // Absolute fetch at 0x10, then relative branch by -2 from instr_pc 0x10.
        issue(1'b1, 1'b1, 2'b01, 8'h10, 8'h10, 8'h11);
        wait_idle();
        br_en = 1'b1; br_mode = 2'b10; br_off = 8'hFE;
        tick();
        br_en = 1'b0; br_off = 8'h00;
        chk("rel_branch_pc", o_pc, 32'h0F);

        // Sequential fetch at 0xFF wraps pc.
        br_en = 1'b1; br_mode = 2'b01; br_target = 8'hFF;
        tick();
        br_en = 1'b0;
        chk("abs_idle_pc", o_pc, 32'hFF);
        issue(1'b1, 1'b0, 2'b00, 8'h00, 8'hFF, 8'h00);
        wait_idle();

        // Branch with fetch in IDLE.
        issue(1'b1, 1'b1, 2'b01, 8'h40, 8'h40, 8'h41);
        wait_idle();

        // Modes none and reserved leave pc alone.
        br_en = 1'b1; br_mode = 2'b00; br_target = 8'h99;
        tick();
        chk("mode00_pc", o_pc, 32'h41);
        br_mode = 2'b11;
        tick();
        br_en = 1'b0;
        chk("mode11_pc", o_pc, 32'h41);

        // Branches during WAIT: the later one wins at completion.
        issue(1'b1, 1'b0, 2'b00, 8'h00, 8'h41, 8'h20);
        br_en = 1'b1; br_mode = 2'b01; br_target = 8'h30;
        tick();
        br_target = 8'h20;
        tick();
        br_en = 1'b0;
        wait_idle();
        tick();

        // Flush during WAIT with a pending branch.
        issue(1'b0, 1'b0, 2'b00, 8'h00, 8'h20, 8'h00);
        br_en = 1'b1; br_mode = 2'b01; br_target = 8'h50;
        tick();
        br_en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", o_busy, 32'd0);
        chk("flush_pc", o_pc, 32'h50);
        chk("flush_instr", o_instr, ram_f(8'h41));
        chk("flush_instr_pc", o_ipc, 32'h41);
        repeat (5) tick();

        // Flush in IDLE has no effect.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_pc", o_pc, 32'h50);
        chk("idle_flush_busy", o_busy, 32'd0);

        // Reset in the middle of WAIT.
        issue(1'b0, 1'b0, 2'b00, 8'h00, 8'h50, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_pc", o_pc, 32'h00);
        chk("midrst_instr", o_instr, 32'h0);
        chk("midrst_instr_pc", o_ipc, 32'h00);
        chk("midrst_valid", o_valid, 32'd0);
        chk("midrst_mem_req", o_mem_req, 32'd0);
        chk("midrst_busy", o_busy, 32'd0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (6) tick();

        // Normal fetch after reset release.
        issue(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h01);
        wait_idle();
        repeat (3) tick();

        chk("lat1_queue_drained", q1.size(), 32'd0);
        chk("lat3_queue_drained", q3.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
